// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - per-frame animation sequencer with pause/single-step and scene select
//
// Purpose: turns vsync into a one-cycle frame_tick_o and, once per frame, advances
// an animation counter, runs a RUN/PAUSED/STEP state machine and selects a scene.
//
// Optional feature: define SCENE_AUTOCYCLE_EN to let scene_o auto-advance every
// 256 advancing frames when manual_i=0. Without it scene_o always follows scene_sel_i.
//
// Ports:
//   clk_i           pixel clock (same clock as the sync generator)
//   reset_i         synchronous, active-high reset
//   vsync_i         vertical sync, polarity set by VSYNC_ACTIVE_LOW
//   pause_req_i     level, 1 freezes the animation
//   step_req_i      rising edge requests one frame advance while paused
//   speed_i         per-frame increment minus 1
//   manual_i        1 = scene from scene_sel_i, 0 = auto-cycle
//   scene_sel_i     manual scene number
//   frame_tick_o    one-cycle pulse at frame start
//   anim_counter_o  animation phase
//   scene_o         active scene
//   paused_o        high in PAUSED and STEP
module frame_sequencer #(
  parameter int VSYNC_ACTIVE_LOW = 1,
  parameter int CNT_W            = 10
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             vsync_i,
  input  logic             pause_req_i,
  input  logic             step_req_i,
  input  logic [2:0]       speed_i,
  input  logic             manual_i,
  input  logic [1:0]       scene_sel_i,
  output logic             frame_tick_o,
  output logic [CNT_W-1:0] anim_counter_o,
  output logic [1:0]       scene_o,
  output logic             paused_o
);

  localparam logic SYNC_ON  = (VSYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic SYNC_OFF = ~SYNC_ON;

  typedef enum logic [1:0] {ST_RUN, ST_PAUSED, ST_STEP} state_t;

  state_t           state_q, state_d;
  logic             vsync_q, vsync_prev_q;
  logic             armed_q;
  logic             step_q;
  logic             step_pending_q, step_pending_d;
  logic [CNT_W-1:0] anim_q, anim_d;
  logic [1:0]       scene_q, scene_d;
  logic             tick;
  logic             step_edge;
  logic             advance;

  // armed_q only sets once a genuine post-reset sample of inactive sync has been
  // taken, so a vsync held active across reset release cannot fake an edge
  // against the reset value of vsync_prev_q.
  assign tick      = armed_q && (vsync_q == SYNC_ON) && (vsync_prev_q == SYNC_OFF);
  assign step_edge = step_req_i && !step_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vsync_q        <= SYNC_OFF;
      vsync_prev_q   <= SYNC_OFF;
      armed_q        <= 1'b0;
      step_q         <= 1'b0;
      step_pending_q <= 1'b0;
      state_q        <= ST_RUN;
      anim_q         <= '0;
      scene_q        <= 2'd0;
    end else begin
      vsync_q        <= vsync_i;
      vsync_prev_q   <= vsync_q;
      armed_q        <= armed_q || (vsync_i == SYNC_OFF);
      step_q         <= step_req_i;
      step_pending_q <= step_pending_d;
      state_q        <= state_d;
      anim_q         <= anim_d;
      scene_q        <= scene_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    anim_d         = anim_q;
    advance        = 1'b0;
    // An edge arriving on the tick cycle itself survives to the next tick;
    // only the previously latched request is consumed or discarded here.
    step_pending_d = step_pending_q || step_edge;
    if (tick) begin
      unique case (state_q)
        ST_RUN: begin
          step_pending_d = step_edge;
          if (pause_req_i) begin
            state_d = ST_PAUSED;
          end else begin
            anim_d  = anim_q + CNT_W'(speed_i) + CNT_W'(1);
            advance = 1'b1;
          end
        end
        ST_PAUSED: begin
          if (!pause_req_i) begin
            state_d        = ST_RUN;
            step_pending_d = step_edge;
          end else if (step_pending_q) begin
            state_d        = ST_STEP;
            anim_d         = anim_q + CNT_W'(1);
            advance        = 1'b1;
            step_pending_d = step_edge;
          end
        end
        ST_STEP: begin
          state_d = pause_req_i ? ST_PAUSED : ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

`ifdef SCENE_AUTOCYCLE_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      frame_cnt_q <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    scene_d     = scene_q;
    if (tick) begin
      if (manual_i) begin
        scene_d = scene_sel_i;
      end else if (advance) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        if (frame_cnt_q == 8'hFF) begin
          scene_d = scene_q + 2'd1;
        end
      end
    end
  end
`else
  logic unused_sigs;
  assign unused_sigs = manual_i | advance;

  always_comb begin
    scene_d = scene_q;
    if (tick) begin
      scene_d = scene_sel_i;
    end
  end
`endif

  assign frame_tick_o   = tick;
  assign anim_counter_o = anim_q;
  assign scene_o        = scene_q;
  assign paused_o       = (state_q != ST_RUN);

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - self-checking bench for frame_sequencer
module tb_frame_sequencer;
  localparam int CNT_W = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             vsync;
  logic             pause_req;
  logic             step_req;
  logic [2:0]       speed;
  logic             manual;
  logic [1:0]       scene_sel;
  logic             frame_tick_o;
  logic [CNT_W-1:0] anim_counter_o;
  logic [1:0]       scene_o;
  logic             paused_o;

  frame_sequencer #(.VSYNC_ACTIVE_LOW(1), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .vsync_i        (vsync),
    .pause_req_i    (pause_req),
    .step_req_i     (step_req),
    .speed_i        (speed),
    .manual_i       (manual),
    .scene_sel_i    (scene_sel),
    .frame_tick_o   (frame_tick_o),
    .anim_counter_o (anim_counter_o),
    .scene_o        (scene_o),
    .paused_o       (paused_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pause;
    int         nstep;
    logic       step_at_tick;
    logic [2:0] spd;
    logic [1:0] ssel;
    int         exp_cnt;
    logic       exp_paused;
    logic [1:0] exp_scene;
  } vec_t;

  typedef struct {
    int         cnt;
    logic       paused;
    logic [1:0] scene;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[18];
  int   checks   = 0;
  int   failures = 0;
  int   ticks    = 0;
  int   model_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // one clock: sample at the falling edge, return 1ns after the rising edge
  task automatic cyc();
    @(negedge clk);
    if (frame_tick_o) ticks++;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int cnt, input logic p, input logic [1:0] sc);
    exp_t e;
    e.cnt = cnt % (1 << CNT_W);
    e.paused = p;
    e.scene = sc;
    sb.push_back(e);
  endtask

  // one frame: sync inactive (optional step pulses), then sync active; exactly one tick expected
  task automatic do_frame(input logic p, input int nstep, input logic sat, input logic [2:0] spd,
                          input logic [1:0] ssel, input logic man, input string tag);
    exp_t e;
    pause_req = p;
    speed     = spd;
    scene_sel = ssel;
    manual    = man;
    vsync     = 1'b1;
    ticks     = 0;
    cyc();
    cyc();
    for (int i = 0; i < nstep; i++) begin
      step_req = 1'b1;
      cyc();
      step_req = 1'b0;
      cyc();
    end
    vsync = 1'b0;
    cyc();
    if (sat) step_req = 1'b1;
    cyc();
    cyc();
    cyc();
    step_req = 1'b0;
    check({tag, " ticks"}, ticks, 1);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard actual=empty required=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " anim_counter"}, anim_counter_o, e.cnt);
      check({tag, " paused"}, paused_o, e.paused);
      check({tag, " scene"}, scene_o, e.scene);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vsync = 1'b1;
    step_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    //            pause nstep sat spd ssel cnt paused scene
    vecs[0]  = '{1'b0, 0, 1'b0, 3'd0, 2'd0,  1, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 0, 1'b0, 3'd0, 2'd0,  2, 1'b0, 2'd0};
    vecs[2]  = '{1'b0, 0, 1'b0, 3'd0, 2'd0,  3, 1'b0, 2'd0};
    vecs[3]  = '{1'b0, 0, 1'b0, 3'd2, 2'd2,  6, 1'b0, 2'd2};
    vecs[4]  = '{1'b0, 1, 1'b0, 3'd0, 2'd2,  7, 1'b0, 2'd2};
    vecs[5]  = '{1'b1, 0, 1'b0, 3'd0, 2'd1,  7, 1'b1, 2'd1};
    vecs[6]  = '{1'b1, 0, 1'b0, 3'd0, 2'd1,  7, 1'b1, 2'd1};
    vecs[7]  = '{1'b1, 2, 1'b0, 3'd0, 2'd1,  8, 1'b1, 2'd1};
    vecs[8]  = '{1'b1, 0, 1'b0, 3'd0, 2'd1,  8, 1'b1, 2'd1};
    vecs[9]  = '{1'b1, 0, 1'b0, 3'd0, 2'd1,  8, 1'b1, 2'd1};
    vecs[10] = '{1'b1, 0, 1'b0, 3'd0, 2'd1,  8, 1'b1, 2'd1};
    vecs[11] = '{1'b1, 0, 1'b1, 3'd0, 2'd1,  8, 1'b1, 2'd1};
    vecs[12] = '{1'b1, 0, 1'b0, 3'd0, 2'd1,  9, 1'b1, 2'd1};
    vecs[13] = '{1'b0, 0, 1'b0, 3'd0, 2'd1,  9, 1'b0, 2'd1};
    vecs[14] = '{1'b0, 0, 1'b0, 3'd7, 2'd3, 17, 1'b0, 2'd3};
    vecs[15] = '{1'b1, 1, 1'b0, 3'd0, 2'd3, 17, 1'b1, 2'd3};
    vecs[16] = '{1'b0, 0, 1'b0, 3'd0, 2'd3, 17, 1'b0, 2'd3};
    vecs[17] = '{1'b0, 0, 1'b0, 3'd4, 2'd0, 22, 1'b0, 2'd0};

    reset = 1'b1;
    vsync = 1'b1;
    pause_req = 1'b0;
    step_req = 1'b0;
    speed = 3'd0;
    manual = 1'b1;
    scene_sel = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset frame_tick", frame_tick_o, 0);
    check("reset anim_counter", anim_counter_o, 0);
    check("reset scene", scene_o, 0);
    check("reset paused", paused_o, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      push(vecs[i].exp_cnt, vecs[i].exp_paused, vecs[i].exp_scene);
      do_frame(vecs[i].pause, vecs[i].nstep, vecs[i].step_at_tick, vecs[i].spd, vecs[i].ssel,
               1'b1, $sformatf("vec%0d", i));
    end

    // counter wrap: 127*8 + 4 = 1020, then +8 -> 4
    do_reset();
    model_cnt = 0;
    for (int i = 0; i < 129; i++) begin
      automatic logic [2:0] s = (i == 127) ? 3'd3 : 3'd7;
      model_cnt = (model_cnt + int'(s) + 1) % (1 << CNT_W);
      push(model_cnt, 1'b0, 2'd0);
      do_frame(1'b0, 0, 1'b0, s, 2'd0, 1'b1, $sformatf("wrap%0d", i));
    end
    check("wrap final", anim_counter_o, 4);

    // reset mid-frame with a pending step and counter 77
    do_reset();
    for (int i = 0; i < 10; i++) begin
      automatic logic [2:0] s = (i == 9) ? 3'd4 : 3'd7;
      push((i + 1) * 8 - ((i == 9) ? 3 : 0), 1'b0, 2'd0);
      do_frame(1'b0, 0, 1'b0, s, 2'd0, 1'b1, $sformatf("pre77_%0d", i));
    end
    push(77, 1'b1, 2'd0);
    do_frame(1'b1, 0, 1'b0, 3'd0, 2'd0, 1'b1, "pause77");
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    cyc();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset frame_tick", frame_tick_o, 0);
    check("midreset anim_counter", anim_counter_o, 0);
    check("midreset scene", scene_o, 0);
    check("midreset paused", paused_o, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ticks = 0;
    repeat (6) cyc();
    check("held active no tick", ticks, 0);
    push(0, 1'b1, 2'd0);
    do_frame(1'b1, 0, 1'b0, 3'd0, 2'd0, 1'b1, "post_reset_pause");
    push(0, 1'b1, 2'd0);
    do_frame(1'b1, 0, 1'b0, 3'd0, 2'd0, 1'b1, "step_discarded");

`ifdef SCENE_AUTOCYCLE_EN
    do_reset();
    for (int i = 0; i < 256; i++) begin
      push(i + 1, 1'b0, (i == 255) ? 2'd1 : 2'd0);
      do_frame(1'b0, 0, 1'b0, 3'd0, 2'd2, 1'b0, $sformatf("auto%0d", i));
    end
    push(257, 1'b0, 2'd3);
    do_frame(1'b0, 0, 1'b0, 3'd0, 2'd3, 1'b1, "auto_manual");
`endif

    check("scoreboard drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter VSYNC_ACTIVE_LOW, default 1: 1 = vsync asserted low, 0 = vsync asserted high.
REQ-002 Parameter CNT_W, default 10: width of the animation counter.
REQ-003 clk  input  1  pixel clock; the same clock that drives hvsync_generator.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 vsync  input  1  vertical sync from hvsync_generator, synchronous to clk.
REQ-006 pause_req  input  1  level; 1 requests a frozen animation.
REQ-007 step_req  input  1  level; each rising edge requests a single-frame advance while paused.
REQ-008 speed  input  3  per-frame increment minus 1 (increment range 1..8).
REQ-009 manual  input  1  1 selects scene_sel directly; 0 selects auto-cycle.
REQ-010 scene_sel  input  2  manual scene number.
REQ-011 frame_tick  output  1  one-cycle pulse at each frame start.
REQ-012 anim_counter  output  CNT_W  animation phase consumed by the pattern datapath.
REQ-013 scene  output  2  active scene number.
REQ-014 paused  output  1  high in PAUSED and STEP.

Function
REQ-015 vsync SHALL be registered each cycle; "sync active" means vsync == ~VSYNC_ACTIVE_LOW.
REQ-016 frame_tick SHALL be high for exactly the one cycle after the first clk edge that samples sync active following a sample of sync inactive; held sync produces no further ticks.
REQ-017 anim_counter, scene, the state and step_pending SHALL update only on cycles where frame_tick is high, so outputs are stable for a whole frame.
REQ-018 The state machine SHALL have three states: RUN, PAUSED and STEP.
REQ-019 In RUN on a tick: if pause_req=1, go to PAUSED with no advance; otherwise anim_counter += speed+1, modulo 2^CNT_W.
REQ-020 In PAUSED on a tick: if pause_req=0, go to RUN with no advance and clear step_pending; else if step_pending=1, anim_counter += 1, clear step_pending and go to STEP; else hold.
REQ-021 In STEP on a tick: go to PAUSED if pause_req=1, else to RUN; no advance.
REQ-022 Step edge detection: step_req SHALL be registered; a 0->1 transition sets sticky step_pending on any cycle; multiple edges within one frame count as one.
REQ-023 In RUN, a tick SHALL clear step_pending (step requests are ignored while running).
REQ-024 If a step edge and a tick occur in the same cycle, the edge SHALL be kept pending for the next tick, not consumed.
REQ-025 An "advancing tick" is a tick that changes anim_counter (REQ-019 advance or REQ-020 step).
REQ-026 Manual scene selection (manual=1, or auto-cycle compiled out): scene <= scene_sel on every tick.

Reset
REQ-027 While reset is high, at every clk edge: state=RUN, anim_counter=0, scene=0, frame_tick=0, paused=0, step_pending=0, scene frame count=0.
REQ-028 Both synchronizer registers SHALL load their inactive values on reset, so a vsync held active through reset release produces no tick until it goes inactive and then active again.
REQ-029 Reset asserted mid-frame or mid-step SHALL discard any pending step.

Configuration
REQ-030 Macro SCENE_AUTOCYCLE_EN, when defined: with manual=0, an 8-bit scene frame count increments on each advancing tick; when it wraps 255->0, scene increments modulo 4 on that same tick.
REQ-031 With manual=1 under SCENE_AUTOCYCLE_EN, the scene frame count SHALL hold its value.
REQ-032 Without SCENE_AUTOCYCLE_EN: no scene frame count register exists, the manual input is ignored, and REQ-026 always applies.

Verification
REQ-033 Reset, then 3 frames with speed=0 and pause_req=0 -> three single-cycle frame_ticks and anim_counter = 1, 2, 3.
REQ-034 speed=7, anim_counter=1020, one tick -> anim_counter=4 (wrap-around).
REQ-035 pause_req=1 before a tick -> paused=1 and anim_counter frozen across 5 ticks; two step_req pulses within one frame -> exactly +1, state STEP, then PAUSED on the next tick.
REQ-036 step_req rises in the same cycle as a tick while PAUSED -> no advance on that tick, +1 on the following tick.
REQ-037 SCENE_AUTOCYCLE_EN defined, manual=0, speed=0, 256 advancing ticks -> scene goes 0->1; manual=1 with scene_sel=3 -> scene=3 on the next tick.
REQ-038 Reset pulse mid-frame with step_pending=1 and anim_counter=77 -> all outputs 0 on the next cycle, and no tick while vsync stays active.
